// File: rtl/reg_dump_reader_if.sv
// Register-dump bus: the debug read port toward the CPU (reg_sel/reg_data)
// and the valid/ready stream of captured register beats toward the consumer.
//   master : the dump reader (drives reg_sel and the out_* payload)
//   slave  : the environment (returns reg_data, drives out_ready)
interface reg_dump_reader_if;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_idx;
    logic        out_last;

    modport master (
        output reg_sel,
        input  reg_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_idx,
        output out_last
    );

    modport slave (
        input  reg_sel,
        output reg_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_idx,
        input  out_last
    );
endinterface

// File: rtl/reg_dump_reader.sv
// Register dump reader: on start, walks register indices FIRST_REG..LAST_REG
// on the CPU debug read port, holds each index for SETTLE cycles, captures
// the returned value and offers it as one valid/ready beat. Register 0 is
// always reported as zero. abort cancels a scan without a done pulse.
// Ports:
//   clk, rstn   : clock, asynchronous active-low reset
//   start       : scan request, only honoured while idle
//   abort       : synchronous scan cancel, wins over start and out_ready
//   bus         : reg_sel/reg_data read port and out_* beat stream
//   busy        : high whenever a scan is in progress
//   done        : one-cycle pulse after the LAST_REG beat is accepted
module reg_dump_reader #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31,
    parameter int unsigned SETTLE    = 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic                      abort,
    reg_dump_reader_if.master         bus,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SELECT = 2'd1;
    localparam logic [1:0] S_SEND   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [4:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [31:0]      data_q, data_d;
    logic [4:0]       oidx_q, oidx_d;
    logic             last_q, last_d;
    logic             busy_d;
    logic             done_d;

    // Next-state and next-output logic; idx doubles as reg_sel, so it is
    // forced back to zero whenever the scan ends.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        oidx_d  = oidx_q;
        last_d  = last_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                idx_d = 5'd0;
                if (start && !abort) begin
                    state_d = S_SELECT;
                    idx_d   = 5'(FIRST_REG);
                    cnt_d   = '0;
                end
            end
            S_SELECT: begin
                if (abort) begin
                    state_d = S_IDLE;
                    idx_d   = 5'd0;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                end else if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    state_d = S_SEND;
                    valid_d = 1'b1;
                    data_d  = (idx_q == 5'd0) ? 32'h0 : bus.reg_data;
                    oidx_d  = idx_q;
                    last_d  = (idx_q == 5'(LAST_REG));
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SEND: begin
                if (abort) begin
                    state_d = S_IDLE;
                    idx_d   = 5'd0;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                end else if (bus.out_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    if (idx_q == 5'(LAST_REG)) begin
                        state_d = S_IDLE;
                        idx_d   = 5'd0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SELECT;
                        idx_d   = idx_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 5'd0;
                cnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            idx_q   <= 5'd0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= 32'h0;
            oidx_q  <= 5'd0;
            last_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            oidx_q  <= oidx_d;
            last_q  <= last_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    assign bus.reg_sel   = idx_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_idx   = oidx_q;
    assign bus.out_last  = last_q;

endmodule
